// File: rtl/simplebus_pkg.sv
// Shared types and constants for the simplebus arbiter slice.
// Holds the arbiter state encoding, default timeouts and a one-hot helper.
package simplebus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANTED,
      ADDR_MID,
      ADDR_LO,
      DATA
   } arb_state_t;

   localparam int DEF_GNT_TIMEOUT  = 16;
   localparam int DEF_DATA_TIMEOUT = 64;
   localparam int MAX_LEADERS      = 16;

   // Out-of-range indices yield an all-zero vector rather than a stray bit.
   function automatic logic [MAX_LEADERS-1:0] onehot(input int idx, input int n);
      logic [MAX_LEADERS-1:0] v;
      v = '0;
      if (idx >= 0 && idx < n && idx < MAX_LEADERS) begin
         v = MAX_LEADERS'(1) << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/simplebus_arbiter_if.sv
// Arbitration bundle between the leaders/snooped bus and the arbiter.
// The arbiter uses the slave modport; leaders and snooping logic use master.
interface simplebus_arbiter_if #(
   parameter int NUM_LEADERS = 4,
   parameter int ID_W        = $clog2(NUM_LEADERS)
);

   logic [NUM_LEADERS-1:0] req;
   logic [NUM_LEADERS-1:0] gnt;
   logic                   start;
   logic                   read;
   logic                   dataValid;
   logic                   busy;
   logic [ID_W-1:0]        owner;
   logic                   timeout_err;
   logic [ID_W-1:0]        err_owner;
   logic                   rd_flag;

   modport master (
      output req, start, read, dataValid,
      input  gnt, busy, owner, timeout_err, err_owner, rd_flag
   );

   modport slave (
      input  req, start, read, dataValid,
      output gnt, busy, owner, timeout_err, err_owner, rd_flag
   );

endinterface

// File: rtl/simplebus_rr_picker.sv
// Combinational round-robin pick: first requester strictly after last_owner_i,
// searching upward and wrapping around.
module simplebus_rr_picker #(
   parameter int NUM_LEADERS = 4,
   parameter int ID_W        = $clog2(NUM_LEADERS)
) (
   input  logic [NUM_LEADERS-1:0] req_i,
   input  logic [ID_W-1:0]        last_owner_i,
   output logic                   pick_valid_o,
   output logic [ID_W-1:0]        pick_idx_o
);

   logic [2*NUM_LEADERS-1:0] reqTwice;
   logic [NUM_LEADERS-1:0]   rotated;
   int                       base;
   int                       slot;

   // Rotating a doubled copy puts the highest-priority candidate at bit 0.
   always_comb begin
      reqTwice     = {req_i, req_i};
      base         = int'(last_owner_i) + 1;
      if (base >= NUM_LEADERS) begin
         base = 0;
      end
      rotated      = NUM_LEADERS'(reqTwice >> base);
      pick_valid_o = 1'b0;
      pick_idx_o   = '0;
      slot         = 0;
      for (int i = 0; i < NUM_LEADERS; i++) begin
         if (!pick_valid_o && rotated[i]) begin
            pick_valid_o = 1'b1;
            slot         = base + i;
            if (slot >= NUM_LEADERS) begin
               slot = slot - NUM_LEADERS;
            end
            pick_idx_o   = ID_W'(slot);
         end
      end
   end

endmodule

// File: rtl/simplebus_arbiter.sv
// Grants one simplebus to one leader at a time and follows the transaction by
// snooping start/read/dataValid, forcing release with an error pulse on stalls.
module simplebus_arbiter
   import simplebus_pkg::*;
#(
   parameter int NUM_LEADERS  = 4,
   parameter int GNT_TIMEOUT  = DEF_GNT_TIMEOUT,
   parameter int DATA_TIMEOUT = DEF_DATA_TIMEOUT,
   parameter int ID_W         = $clog2(NUM_LEADERS)
) (
   input  logic                clock,
   input  logic                resetN,
   simplebus_arbiter_if.slave  bus
);

   localparam int WAIT_W = $clog2(GNT_TIMEOUT + 1);
   localparam int DATA_W = $clog2(DATA_TIMEOUT + 1);

   arb_state_t             state_q, state_d;
   logic [NUM_LEADERS-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]        owner_q, owner_d;
   logic [ID_W-1:0]        lastOwner_q, lastOwner_d;
   logic [ID_W-1:0]        errOwner_q, errOwner_d;
   logic                   timeoutErr_q, timeoutErr_d;
   logic                   rdFlag_q, rdFlag_d;
   logic [WAIT_W-1:0]      waitCnt_q, waitCnt_d;
   logic [DATA_W-1:0]      dataCnt_q, dataCnt_d;
   logic                   timeoutHit;
   logic                   pickValid;
   logic [ID_W-1:0]        pickIdx;

   simplebus_rr_picker #(
      .NUM_LEADERS (NUM_LEADERS),
      .ID_W        (ID_W)
   ) u_picker (
      .req_i        (bus.req),
      .last_owner_i (lastOwner_q),
      .pick_valid_o (pickValid),
      .pick_idx_o   (pickIdx)
   );

   // Reset seeds lastOwner with the top index so leader 0 wins first.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         owner_q      <= '0;
         lastOwner_q  <= ID_W'(NUM_LEADERS - 1);
         errOwner_q   <= '0;
         timeoutErr_q <= 1'b0;
         rdFlag_q     <= 1'b0;
         waitCnt_q    <= '0;
         dataCnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         owner_q      <= owner_d;
         lastOwner_q  <= lastOwner_d;
         errOwner_q   <= errOwner_d;
         timeoutErr_q <= timeoutErr_d;
         rdFlag_q     <= rdFlag_d;
         waitCnt_q    <= waitCnt_d;
         dataCnt_q    <= dataCnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      dataCnt_d  = dataCnt_q;
      timeoutHit = 1'b0;
      unique case (state_q)
         IDLE: begin
            waitCnt_d = '0;
            if (pickValid) begin
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            if (bus.start) begin
               state_d = ADDR_MID;
            end else if (!bus.req[owner_q]) begin
               state_d = IDLE;
            end else if (waitCnt_q == WAIT_W'(GNT_TIMEOUT - 1)) begin
               state_d    = IDLE;
               timeoutHit = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         ADDR_MID: begin
            state_d = ADDR_LO;
         end
         ADDR_LO: begin
            state_d   = DATA;
            dataCnt_d = '0;
         end
         DATA: begin
            // Only a clean 1 completes; a floating dataValid must not.
            if (bus.dataValid === 1'b1) begin
               state_d = IDLE;
            end else if (dataCnt_q == DATA_W'(DATA_TIMEOUT - 1)) begin
               state_d    = IDLE;
               timeoutHit = 1'b1;
            end else if (dataCnt_q != '1) begin
               dataCnt_d = dataCnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs follow the transition being taken this cycle.
   always_comb begin
      gnt_d        = gnt_q;
      owner_d      = owner_q;
      lastOwner_d  = lastOwner_q;
      errOwner_d   = errOwner_q;
      timeoutErr_d = timeoutHit;
      rdFlag_d     = rdFlag_q;
      if (state_q == IDLE && state_d == GRANTED) begin
         gnt_d   = NUM_LEADERS'(onehot(int'(pickIdx), NUM_LEADERS));
         owner_d = pickIdx;
      end
      if (state_d == IDLE) begin
         gnt_d = '0;
      end
      if ((state_q == GRANTED || state_q == DATA) && state_d == IDLE) begin
         lastOwner_d = owner_q;
      end
      if (timeoutHit) begin
         errOwner_d = owner_q;
      end
      if (state_q == ADDR_LO) begin
         rdFlag_d = bus.read;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.owner       = owner_q;
   assign bus.timeout_err = timeoutErr_q;
   assign bus.err_owner   = errOwner_q;
   assign bus.rd_flag     = rdFlag_q;

endmodule
